vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_axis_counter.sv | 38 +++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing constants, totals,
// the 10-bit coordinate type and a half-open span helper for sync decode.
// Imported by the timing generator, its axis counters and overlay generators.
package vga_pkg;

  localparam int COORD_W   = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  typedef logic [COORD_W-1:0] coord_t;

  // True when lo <= v < hi.
  function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one screen axis: counts 0..LAST, wraps to 0 on en at LAST.
// Latency: value updates one clk after en; value_next/at_last are combinational.
// Backpressure: none; en is the only advance qualifier.
// Ports: clk, rst (sync, active-high), en (advance), value (registered count),
//        value_next (count after this edge), at_last (value == LAST).
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int LAST = 799
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t value,
  output coord_t value_next,
  output logic   at_last
);

  localparam coord_t LAST_C = coord_t'(LAST);

  assign at_last = (value == LAST_C);

  always_comb begin
    value_next = value;
    if (en) begin
      value_next = at_last ? '0 : value + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: x/y counters plus registered hsync, vsync,
// active, line_end and frame_start; all outputs registered, zero skew to x/y.
// Latency: one clk from a ce advance to the new coordinate and its decodes.
// Backpressure: ce=0 freezes every output; line_end/frame_start drop to 0.
// Ports: clk, rst (sync, active-high), ce (pixel advance), x, y, hsync/vsync
//        (active low), active, line_end, frame_start, frame_cnt[7:0].
// Optional: define VGA_FRAME_CNT_EN for a live frame counter; otherwise
//        frame_cnt is constant 0 and no counter flops are built.
module vga_timing_gen #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  output logic [vga_pkg::COORD_W-1:0] x,
  output logic [vga_pkg::COORD_W-1:0] y,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       active,
  output logic                       line_end,
  output logic                       frame_start,
  output logic [7:0]                 frame_cnt
);

  import vga_pkg::*;

  localparam int LINE_LEN  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int FRAME_LEN = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);
  localparam coord_t HS_BEG  = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_BEG  = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t x_next;
  coord_t y_next;
  logic   x_last;
  logic   y_last;
  logic   frame_wrap;

  vga_axis_counter #(.LAST(LINE_LEN - 1)) u_x_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (ce),
    .value      (x),
    .value_next (x_next),
    .at_last    (x_last)
  );

  // y only moves on the advance that wraps x.
  vga_axis_counter #(.LAST(FRAME_LEN - 1)) u_y_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (ce & x_last),
    .value      (y),
    .value_next (y_next),
    .at_last    (y_last)
  );

  assign frame_wrap = ce & x_last & y_last;

  // Decodes are taken from the counters' next values so they land in the
  // same cycle as the coordinate they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b1;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_end    <= ce & x_last;
      frame_start <= frame_wrap;
      if (ce) begin
        hsync  <= ~in_span(x_next, HS_BEG, HS_END);
        vsync  <= ~in_span(y_next, VS_BEG, VS_END);
        active <= (x_next < H_VIS_C) && (y_next < V_VIS_C);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Steps on the same edge that raises frame_start; wraps mod 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for reset/line/ce-toggle/mid-reset
// behaviour, plus a shrunken 16x10 instance for full-frame and frame counter.
// Small timing: H 8/2/3/3 (hsync low x=10..12), V 6/1/2/1 (vsync low y=7..8).
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce  = 1'b1;

  logic [9:0] d_x, d_y;
  logic       d_hsync, d_vsync, d_active, d_line_end, d_frame_start;
  logic [7:0] d_frame_cnt;

  logic [9:0] s_x, s_y;
  logic       s_hsync, s_vsync, s_active, s_line_end, s_frame_start;
  logic [7:0] s_frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .x           (d_x),
    .y           (d_y),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .active      (d_active),
    .line_end    (d_line_end),
    .frame_start (d_frame_start),
    .frame_cnt   (d_frame_cnt)
  );

  vga_timing_gen #(
    .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_VISIBLE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
  ) u_small (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .x           (s_x),
    .y           (s_y),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .active      (s_active),
    .line_end    (s_line_end),
    .frame_start (s_frame_start),
    .frame_cnt   (s_frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Small-instance frame is 160 advances.
  function automatic int exp_fc(input int n);
`ifdef VGA_FRAME_CNT_EN
    return (n / 160) % 256;
`else
    return 0;
`endif
  endfunction

  initial begin
    int act_fall_x, hs_low, hs_first, hs_last, le_cnt, le_at, x_err;
    int dbl_err, prev_le;
    int xe, ye, xy_err, sync_err, act_err, pulse_err, fc_err;
    int fs_cnt, fs_first, fs_first_xy, vs_low;

    // Reset with ce high: reset wins.
    rst = 1'b1; ce = 1'b1;
    tick; tick;
    chk("rst_x",      d_x, 0);
    chk("rst_y",      d_y, 0);
    chk("rst_hsync",  d_hsync, 1);
    chk("rst_vsync",  d_vsync, 1);
    chk("rst_active", d_active, 1);
    chk("rst_le",     d_line_end, 0);
    chk("rst_fs",     d_frame_start, 0);
    chk("rst_fc",     d_frame_cnt, 0);

    rst = 1'b0;
    tick;
    chk("rel_x",  d_x, 1);
    chk("rel_y",  d_y, 0);
    chk("rel_fs", d_frame_start, 0);

    // One full line on the default timing (advance n = 1..800).
    act_fall_x = -1; hs_low = 0; hs_first = -1; hs_last = -1;
    le_cnt = 0; le_at = -1; x_err = 0;
    for (int n = 1; n <= 800; n++) begin
      if (n > 1) begin
        if (d_active) begin
          tick;
          if (!d_active && act_fall_x < 0) act_fall_x = int'(d_x);
        end else begin
          tick;
        end
      end
      if (int'(d_x) != n % 800) x_err++;
      if (!d_hsync) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(d_x);
        hs_last = int'(d_x);
      end
      if (d_line_end) begin
        le_cnt++;
        le_at = n;
      end
    end
    chk("line_x_track",   x_err, 0);
    chk("line_act_fall",  act_fall_x, 640);
    chk("line_hs_cycles", hs_low, 96);
    chk("line_hs_first",  hs_first, 656);
    chk("line_hs_last",   hs_last, 751);
    chk("line_le_count",  le_cnt, 1);
    chk("line_le_at",     le_at, 800);
    chk("line_end_x",     d_x, 0);
    chk("line_end_y",     d_y, 1);

    // ce alternating 1/0: one line in 1600 clocks, pulses one cycle wide.
    le_cnt = 0; dbl_err = 0; x_err = 0;
    prev_le = int'(d_line_end);
    for (int i = 0; i < 1600; i++) begin
      ce = (i % 2 == 0);
      tick;
      if (int'(d_x) != (i / 2 + 1) % 800) x_err++;
      if (d_line_end) le_cnt++;
      if (d_line_end && prev_le == 1) dbl_err++;
      prev_le = int'(d_line_end);
    end
    ce = 1'b1;
    chk("tog_x_track", x_err, 0);
    chk("tog_le_count", le_cnt, 1);
    chk("tog_no_wide",  dbl_err, 0);
    chk("tog_end_x",    d_x, 0);
    chk("tog_end_y",    d_y, 2);

    // Reset mid-line: default lands on (700,2), small on (12,3).
    rst = 1'b1; tick; rst = 1'b0;
    for (int i = 0; i < 2300; i++) tick;
    chk("pre_rst_dx", d_x, 700);
    chk("pre_rst_dy", d_y, 2);
    chk("pre_rst_sx", s_x, 12);
    chk("pre_rst_sy", s_y, 3);
    chk("pre_rst_hs", d_hsync, 0);
    chk("pre_rst_shs", s_hsync, 0);
    rst = 1'b1;
    tick;
    chk("mid_rst_x",     d_x, 0);
    chk("mid_rst_y",     d_y, 0);
    chk("mid_rst_hs",    d_hsync, 1);
    chk("mid_rst_vs",    d_vsync, 1);
    chk("mid_rst_act",   d_active, 1);
    chk("mid_rst_sx",    s_x, 0);
    chk("mid_rst_shs",   s_hsync, 1);
    chk("mid_rst_sact",  s_active, 1);
    rst = 1'b0;
    tick;
    chk("mid_rel_x",  d_x, 1);
    chk("mid_rel_sx", s_x, 1);
    chk("mid_rel_sy", s_y, 0);

    // 256 small frames (advance n = 2..40960), checked against the formulas.
    xy_err = 0; sync_err = 0; act_err = 0; pulse_err = 0; fc_err = 0;
    fs_cnt = 0; fs_first = -1; fs_first_xy = -1; vs_low = 0;
    for (int n = 2; n <= 40960; n++) begin
      tick;
      xe = n % 16;
      ye = (n / 16) % 10;
      if (int'(s_x) != xe || int'(s_y) != ye) xy_err++;
      if (s_hsync != !(xe >= 10 && xe < 13)) sync_err++;
      if (s_vsync != !(ye >= 7 && ye < 9)) sync_err++;
      if (s_active != (xe < 8 && ye < 6)) act_err++;
      if (s_line_end != (xe == 0)) pulse_err++;
      if (s_frame_start != (xe == 0 && ye == 0)) pulse_err++;
      if (int'(s_frame_cnt) != exp_fc(n)) fc_err++;
      if (n <= 160 && !s_vsync) vs_low++;
      if (s_frame_start) begin
        fs_cnt++;
        if (fs_first < 0) begin
          fs_first = n;
          fs_first_xy = int'(s_x) + int'(s_y);
        end
      end
      if (n == 160) chk("fc_after_1", s_frame_cnt, exp_fc(160));
      if (n == 480) chk("fc_after_3", s_frame_cnt, exp_fc(480));
    end
    chk("frm_xy_track",  xy_err, 0);
    chk("frm_sync",      sync_err, 0);
    chk("frm_active",    act_err, 0);
    chk("frm_pulses",    pulse_err, 0);
    chk("frm_fc_track",  fc_err, 0);
    chk("frm_vs_cycles", vs_low, 32);
    chk("frm_fs_first",  fs_first, 160);
    chk("frm_fs_at_00",  fs_first_xy, 0);
    chk("frm_fs_count",  fs_cnt, 256);
    chk("fc_after_256",  s_frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
